hdbn_encoder: RTL
=================

HDBN_ENCODER -- requirements
Module: hdbn_encoder

Interface
REQ-001 SHALL have parameter ZRUN, default 4, meaning the zero-run length that triggers substitution (4 gives HDB3); legal range 3..8.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_en  input  1  data_in is valid and accepted on this edge.
REQ-005 SHALL have data_in  input  1  binary NRZ data bit.
REQ-006 SHALL have out_valid  output  1  out_p, out_n and out_sym carry a valid symbol this cycle.
REQ-007 SHALL have out_p  output  1  positive pulse.
REQ-008 SHALL have out_n  output  1  negative pulse.
REQ-009 SHALL have out_sym  output  2  symbol type (ZERO, ONE, B, V) of the current output.
REQ-010 SHALL have v_count and b_count  output  16 each  count of inserted V and B symbols; present only with HDBN_STAT_EN.

Function
REQ-011 SHALL tag each accepted bit at input: 1 -> ONE, 0 -> ZERO, then push the tag into a ZRUN-deep delay line.
REQ-012 SHALL keep a zero-run counter: clear it on an accepted 1 or after a substitution; increment it on an accepted 0.
REQ-013 SHALL substitute when an accepted 0 completes a run of ZRUN zeros: the newest entry becomes V; if the pulse parity is even, the oldest run entry (pushed ZRUN-1 beats earlier) also becomes B.
REQ-014 SHALL track pulse parity as ONE/B symbols entered since the last V: reset to even, toggle per ONE, clear on V insertion.
REQ-015 SHALL assign output polarity from last_pol, the polarity of the last emitted pulse: ONE and B use the opposite of last_pol; V uses the same as last_pol; ZERO gives out_p = out_n = 0.
REQ-016 SHALL never assert out_p and out_n together.
REQ-017 SHALL, with in_en continuously high, present the symbol for the bit accepted at edge t after edge t+ZRUN (fixed latency of ZRUN beats).
REQ-018 SHALL hold the delay line, counters, parity and last_pol, and drive out_valid = 0, on any cycle with in_en = 0; no bit is lost or duplicated.
REQ-019 SHALL keep out_valid low until ZRUN bits have been accepted after reset; priming entries are never emitted.
REQ-020 SHALL handle consecutive runs (2*ZRUN or more zeros) as independent substitutions, each with its own parity decision.

Reset
REQ-021 SHALL, on rst_n low, immediately clear the delay line to ZERO, zero counter to 0, parity to even, last_pol to negative, out_valid/out_p/out_n to 0, out_sym to ZERO, and any counters to 0.
REQ-022 SHALL discard all in-flight bits on reset mid-stream and restart priming per REQ-019.

Configuration
REQ-023 SHALL compile v_count/b_count and their logic only when macro HDBN_STAT_EN is defined; each counter increments when a V/B is emitted with out_valid and saturates at 16'hFFFF.
REQ-024 SHALL, without HDBN_STAT_EN, omit those ports entirely; encoder behaviour is unchanged.

Structure
REQ-025 SHALL place the symbol codes (ZERO 2'b00, ONE 2'b01, B 2'b10, V 2'b11) and the reset-level constant RST_EN in the shared define file.
REQ-026 SHALL implement the output polarity stage (REQ-015/016) as sub-module hdbn_polarity; the delay line and substitution logic stay in hdbn_encoder.

Verification (ZRUN=4, in_en=1, sequences listed post-priming, + = out_p, - = out_n)
REQ-027 SHALL cover: bits 1,0,0,0,0,1 after reset -> + 0 0 0 + - with out_sym ONE,Z,Z,Z,V,ONE.
REQ-028 SHALL cover: eight 0s after reset -> + 0 0 + - 0 0 - (B00V, then B00V).
REQ-029 SHALL cover: 1,1,0,0,0,0 -> + - + 0 0 + (even parity, so B00V).
REQ-030 SHALL cover: in_en toggling 1/0 on alternate cycles with REQ-027 data -> identical symbol sequence, and out_valid low on every in_en-low cycle.
REQ-031 SHALL cover: rst_n pulsed after 3 zeros -> outputs clear at once, and the next 4 zeros yield + 0 0 +.
REQ-032 SHALL cover: HDBN_STAT_EN with a long all-zero stream -> v_count = b_count = number of runs, saturating at 16'hFFFF.

Source files
------------

// File: rtl/hdbn_encoder_pkg.sv
// Shared symbol codes, reset level and small helpers for the HDBn encoder.
// HDBN_STAT_EN (optional macro) enables the V/B statistics counters in hdbn_encoder.
package hdbn_encoder_pkg;

    localparam logic RST_EN = 1'b0;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_ONE  = 2'b01,
        SYM_B    = 2'b10,
        SYM_V    = 2'b11
    } sym_t;

    localparam int CNT_W = 4;

    function automatic logic is_pulse(input sym_t s);
        return (s != SYM_ZERO);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/hdbn_polarity.sv
// Output polarity stage: maps symbols to bipolar pulses, tracking last pulse polarity.
// ONE/B alternate against the last pulse; V repeats it, which is the bipolar violation.
module hdbn_polarity
    import hdbn_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  sym_t       sym_in,
    output logic       out_valid,
    output logic       out_p,
    output logic       out_n,
    output logic [1:0] out_sym
);

    logic last_pol_r;   // 1'b1 = last pulse positive
    logic pol_s;
    logic pulse_s;

    // Polarity of the symbol about to be emitted
    always_comb begin
        pol_s   = last_pol_r;
        pulse_s = is_pulse(sym_in);
        case (sym_in)
            SYM_ONE,
            SYM_B:    pol_s = ~last_pol_r;
            SYM_V:    pol_s = last_pol_r;
            SYM_ZERO: pol_s = last_pol_r;
            default:  pol_s = last_pol_r;
        endcase
    end

    // Registered line outputs and last-pulse polarity
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_EN) begin
            last_pol_r <= 1'b0;
            out_valid  <= 1'b0;
            out_p      <= 1'b0;
            out_n      <= 1'b0;
            out_sym    <= SYM_ZERO;
        end else if (sym_valid) begin
            out_valid  <= 1'b1;
            out_sym    <= sym_in;
            out_p      <= pulse_s & pol_s;
            out_n      <= pulse_s & ~pol_s;
            last_pol_r <= pulse_s ? pol_s : last_pol_r;
        end else begin
            last_pol_r <= last_pol_r;
            out_valid  <= 1'b0;
            out_p      <= 1'b0;
            out_n      <= 1'b0;
            out_sym    <= SYM_ZERO;
        end
    end

endmodule

// File: rtl/hdbn_encoder.sv
// HDBn line encoder: ZRUN-deep symbol delay line with B..V zero-run substitution.
// Define HDBN_STAT_EN to add saturating v_count/b_count outputs.
module hdbn_encoder
    import hdbn_encoder_pkg::*;
#(
    parameter int ZRUN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_en,
    input  logic        data_in,
    output logic        out_valid,
    output logic        out_p,
    output logic        out_n,
    output logic [1:0]  out_sym
`ifdef HDBN_STAT_EN
    ,
    output logic [15:0] v_count,
    output logic [15:0] b_count
`endif
);

    localparam logic [CNT_W-1:0] ZRUN_C  = CNT_W'(ZRUN);
    localparam logic [CNT_W-1:0] ZRUN_M1 = CNT_W'(ZRUN - 1);

    sym_t             dl_r [ZRUN];   // [0] newest, [ZRUN-1] oldest
    logic [CNT_W-1:0] zcnt_r;
    logic [CNT_W-1:0] prime_r;
    logic             parity_r;      // 1'b1 = odd pulse count since last V
    logic             subst_s;
    logic             emit_valid_s;
    sym_t             emit_sym_s;

    // Substitution trigger and the symbol leaving the delay line
    always_comb begin
        subst_s      = in_en & ~data_in & (zcnt_r == ZRUN_M1);
        emit_valid_s = in_en & (prime_r == ZRUN_C);
        emit_sym_s   = dl_r[ZRUN-1];
    end

    // Delay line, zero-run counter, pulse parity and priming count
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_EN) begin
            for (int i = 0; i < ZRUN; i++) begin
                dl_r[i] <= SYM_ZERO;
            end
            zcnt_r   <= {CNT_W{1'b0}};
            prime_r  <= {CNT_W{1'b0}};
            parity_r <= 1'b0;
        end else if (in_en) begin
            for (int i = ZRUN - 1; i > 0; i--) begin
                dl_r[i] <= dl_r[i-1];
            end
            if (data_in) begin
                dl_r[0]  <= SYM_ONE;
                zcnt_r   <= {CNT_W{1'b0}};
                parity_r <= ~parity_r;
            end else if (subst_s) begin
                // The run's first zero sits at [ZRUN-2] and lands in [ZRUN-1] this edge
                dl_r[0] <= SYM_V;
                if (!parity_r) begin
                    dl_r[ZRUN-1] <= SYM_B;
                end else begin
                    dl_r[ZRUN-1] <= dl_r[ZRUN-2];
                end
                zcnt_r   <= {CNT_W{1'b0}};
                parity_r <= 1'b0;
            end else begin
                dl_r[0]  <= SYM_ZERO;
                zcnt_r   <= zcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                parity_r <= parity_r;
            end
            if (prime_r != ZRUN_C) begin
                prime_r <= prime_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                prime_r <= prime_r;
            end
        end else begin
            for (int i = 0; i < ZRUN; i++) begin
                dl_r[i] <= dl_r[i];
            end
            zcnt_r   <= zcnt_r;
            prime_r  <= prime_r;
            parity_r <= parity_r;
        end
    end

    hdbn_polarity u_polarity (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_valid (emit_valid_s),
        .sym_in    (emit_sym_s),
        .out_valid (out_valid),
        .out_p     (out_p),
        .out_n     (out_n),
        .out_sym   (out_sym)
    );

`ifdef HDBN_STAT_EN
    // Saturating counts of emitted V and B symbols
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_EN) begin
            v_count <= 16'd0;
            b_count <= 16'd0;
        end else if (emit_valid_s) begin
            v_count <= (emit_sym_s == SYM_V) ? sat_inc(v_count) : v_count;
            b_count <= (emit_sym_s == SYM_B) ? sat_inc(b_count) : b_count;
        end else begin
            v_count <= v_count;
            b_count <= b_count;
        end
    end
`endif

endmodule
